// File: rtl/seqmult_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seqmult_pkg : FSM encoding and width helpers for seqmult_unit    |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package seqmult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to hold any value in 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seqmult_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seqmult_if : request/result bundle of the sequential multiplier  |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
interface seqmult_if #(
    parameter int DATAWIDTH = 8
);
    logic                     sStart;
    logic                     sSigned;
    logic [DATAWIDTH-1:0]     sDataInA;
    logic [DATAWIDTH-1:0]     sDataInB;
    logic                     sReady;
    logic                     sDone;
    logic [2*DATAWIDTH-1:0]   sProduct;
    logic [DATAWIDTH-1:0]     sDataOut;
    logic                     sOverflow;
    logic                     sZero;
    logic                     sNegative;

    modport master (
        output sStart, sSigned, sDataInA, sDataInB,
        input  sReady, sDone, sProduct, sDataOut, sOverflow, sZero, sNegative
    );

    modport slave (
        input  sStart, sSigned, sDataInA, sDataInB,
        output sReady, sDone, sProduct, sDataOut, sOverflow, sZero, sNegative
    );
endinterface
`default_nettype wire

// File: rtl/seqmult_unit_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shiftadd_core : unsigned shift-and-add datapath, one bit / cycle |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module shiftadd_core #(
    parameter int DATAWIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   lowRst,
    input  wire logic                   load,
    input  wire logic                   step,
    input  wire logic [DATAWIDTH-1:0]   mcand_mag,
    input  wire logic [DATAWIDTH-1:0]   mplier_mag,
    output logic      [2*DATAWIDTH-1:0] product
);
    logic [DATAWIDTH-1:0] r_mcand;
    logic [DATAWIDTH-1:0] r_acc;
    logic [DATAWIDTH-1:0] r_mpl;
    logic [DATAWIDTH:0]   w_sum;

    always_comb begin
        w_sum = {1'b0, r_acc} + (r_mpl[0] ? {1'b0, r_mcand} : '0);
    end

    // The carry-out becomes the new accumulator MSB as {carry, acc, mpl} shifts right.
    always_ff @(posedge clk) begin
        if (!lowRst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mpl   <= '0;
        end else if (load) begin
            r_mcand <= mcand_mag;
            r_acc   <= '0;
            r_mpl   <= mplier_mag;
        end else if (step) begin
            r_acc   <= w_sum[DATAWIDTH:1];
            r_mpl   <= {w_sum[0], r_mpl[DATAWIDTH-1:1]};
        end
    end

    assign product = {r_acc, r_mpl};

endmodule
`default_nettype wire

// File: rtl/seqmult_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seqmult_unit : signed/unsigned sequential multiplier with flags  |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module seqmult_unit
    import seqmult_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  lowRst,
    seqmult_if.slave   bus
);
    localparam int CNT_W = clog2(DATAWIDTH + 1);
    localparam int PW    = 2 * DATAWIDTH;
    localparam logic [DATAWIDTH-1:0] ONE_D   = DATAWIDTH'(1);
    localparam logic [PW-1:0]        ONE_P   = PW'(1);
    localparam logic [CNT_W-1:0]     ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_TOP = CNT_W'(DATAWIDTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_signed;

    logic               w_accept;
    logic               w_step;
    logic [DATAWIDTH-1:0] w_mag_a;
    logic [DATAWIDTH-1:0] w_mag_b;
    logic [PW-1:0]      w_mag_prod;
    logic [PW-1:0]      w_result;
    logic               w_ovf;

    assign w_accept = (r_state == IDLE) && bus.sStart;
    assign w_step   = (r_state == CALC) && (r_cnt != '0);

    // -2^(N-1) maps to 2^(N-1), which still fits the unsigned N-bit datapath.
    always_comb begin
        w_mag_a = (bus.sSigned && bus.sDataInA[DATAWIDTH-1]) ? (~bus.sDataInA + ONE_D) : bus.sDataInA;
        w_mag_b = (bus.sSigned && bus.sDataInB[DATAWIDTH-1]) ? (~bus.sDataInB + ONE_D) : bus.sDataInB;
    end

    shiftadd_core #(
        .DATAWIDTH (DATAWIDTH)
    ) u_core (
        .clk        (clk),
        .lowRst     (lowRst),
        .load       (w_accept),
        .step       (w_step),
        .mcand_mag  (w_mag_a),
        .mplier_mag (w_mag_b),
        .product    (w_mag_prod)
    );

    always_comb begin
        w_result = r_sign ? (~w_mag_prod + ONE_P) : w_mag_prod;
        if (r_signed) begin
            w_ovf = !((&w_result[PW-1:DATAWIDTH-1]) || (~|w_result[PW-1:DATAWIDTH-1]));
        end else begin
            w_ovf = |w_result[PW-1:DATAWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!lowRst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sign        <= 1'b0;
            r_signed      <= 1'b0;
            bus.sReady    <= 1'b1;
            bus.sDone     <= 1'b0;
            bus.sProduct  <= '0;
            bus.sDataOut  <= '0;
            bus.sOverflow <= 1'b0;
            bus.sZero     <= 1'b0;
            bus.sNegative <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.sStart) begin
                        r_signed   <= bus.sSigned;
                        r_sign     <= bus.sSigned & (bus.sDataInA[DATAWIDTH-1] ^ bus.sDataInB[DATAWIDTH-1]);
                        r_cnt      <= CNT_TOP;
                        bus.sReady <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - ONE_C;
                    end
                end
                FIX: begin
                    bus.sProduct  <= w_result;
                    bus.sDataOut  <= w_result[DATAWIDTH-1:0];
                    bus.sOverflow <= w_ovf;
                    bus.sZero     <= (w_result == '0);
                    bus.sNegative <= r_signed & w_result[PW-1];
                    bus.sDone     <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    bus.sDone  <= 1'b0;
                    bus.sReady <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seqmult_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seqmult_unit : directed + random checks against integer model |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module tb_seqmult_unit;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic lowRst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seqmult_if #(.DATAWIDTH(DW)) bus ();

    seqmult_unit #(.DATAWIDTH(DW)) dut (
        .clk    (clk),
        .lowRst (lowRst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs_clear(input string tag);
        chk({tag, "_ready"},   {31'd0, bus.sReady},     32'd1);
        chk({tag, "_done"},    {31'd0, bus.sDone},      32'd0);
        chk({tag, "_product"}, {16'd0, bus.sProduct},   32'd0);
        chk({tag, "_dataout"}, {24'd0, bus.sDataOut},   32'd0);
        chk({tag, "_ovf"},     {31'd0, bus.sOverflow},  32'd0);
        chk({tag, "_zero"},    {31'd0, bus.sZero},      32'd0);
        chk({tag, "_neg"},     {31'd0, bus.sNegative},  32'd0);
    endtask

    // Launch one product; optionally poke sStart (1x1) during CALC and DONE.
    task automatic op_check(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic sgn, input bit pulses, input string tag);
        int va, vb, p;
        int done_cnt, done_k, ready_low;
        logic [15:0] exp_prod;
        done_cnt  = 0;
        done_k    = -1;
        ready_low = 0;

        @(negedge clk);
        bus.sDataInA = a;
        bus.sDataInB = b;
        bus.sSigned  = sgn;
        bus.sStart   = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.sDone) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bus.sReady) break;
            ready_low++;
            @(negedge clk);
            bus.sStart   = pulses && (k == 3 || k == 10);
            bus.sDataInA = bus.sStart ? 8'd1 : 8'($urandom);
            bus.sDataInB = bus.sStart ? 8'd1 : 8'($urandom);
            bus.sSigned  = 1'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.sStart = 1'b0;

        va = sgn ? int'($signed(a)) : int'(a);
        vb = sgn ? int'($signed(b)) : int'(b);
        p  = va * vb;
        exp_prod = p[15:0];

        chk({tag, "_product"}, {16'd0, bus.sProduct}, {16'd0, exp_prod});
        chk({tag, "_dataout"}, {24'd0, bus.sDataOut}, {24'd0, exp_prod[7:0]});
        chk({tag, "_ovf"},     {31'd0, bus.sOverflow},
            sgn ? 32'(p < -128 || p > 127) : 32'(p > 255));
        chk({tag, "_zero"},    {31'd0, bus.sZero},     32'(p == 0));
        chk({tag, "_neg"},     {31'd0, bus.sNegative}, 32'(sgn && p < 0));
        chk({tag, "_done_cnt"}, 32'(done_cnt),  32'd1);
        chk({tag, "_latency"},  32'(done_k),    32'd10);
        chk({tag, "_busy_len"}, 32'(ready_low), 32'd11);
    endtask

    initial begin
        int done_cnt;
        bus.sStart   = 1'b0;
        bus.sSigned  = 1'b0;
        bus.sDataInA = '0;
        bus.sDataInB = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_clear("reset");
        @(negedge clk);
        lowRst = 1'b1;

        op_check(8'd3,   8'd2,   1'b0, 1'b0, "u3x2");
        op_check(8'd255, 8'd255, 1'b0, 1'b0, "u255x255");
        op_check(8'h80,  8'h80,  1'b1, 1'b0, "s_m128xm128");
        op_check(8'h80,  8'h01,  1'b1, 1'b0, "s_m128x1");
        op_check(8'h00,  8'hFB,  1'b1, 1'b0, "s_0xm5");
        op_check(8'h7F,  8'h80,  1'b1, 1'b0, "s_127xm128");
        op_check(8'd7,   8'd9,   1'b0, 1'b1, "u7x9_pulses");

        // Abort 100x100 inside CALC: prior 0x3F result must be wiped.
        @(negedge clk);
        bus.sDataInA = 8'd100;
        bus.sDataInB = 8'd100;
        bus.sSigned  = 1'b0;
        bus.sStart   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sStart = 1'b0;
        repeat (3) @(negedge clk);
        lowRst = 1'b0;
        @(negedge clk);
        lowRst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.sDone) done_cnt++;
        end
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk_outputs_clear("abort");

        op_check(8'd12, 8'd12, 1'b0, 1'b0, "u12x12");

        // Reset coincident with a request: request dropped.
        @(negedge clk);
        lowRst       = 1'b0;
        bus.sStart   = 1'b1;
        bus.sDataInA = 8'd5;
        bus.sDataInB = 8'd5;
        @(negedge clk);
        lowRst     = 1'b1;
        bus.sStart = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.sDone) done_cnt++;
        end
        chk("rst_start_done_cnt", 32'(done_cnt), 32'd0);
        chk_outputs_clear("rst_start");

        for (int i = 0; i < 16; i++) begin
            op_check(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
